rptr_ctrl_sync: RTL
===================

// Module: rptr_ctrl_sync
// PURPOSE
//  Read-side pointer controller for the async FIFO, successor to the basic read-pointer handler.
//  - Synchronises the write-domain gray pointer internally with a SYNC_STAGES-deep chain.
//  - Keeps the binary and gray read pointers and the RAM read address.
//  - Registers empty, almost_empty and the fill level (rlevel) in the rclk domain.
//  - Sits between the dual-port FIFO RAM and the read-side consumer (DSP sample path).
// PARAMETERS
//  PTR_WIDTH    3  address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
//  SYNC_STAGES  2  flops in the g_wptr synchroniser chain; legal range 2..4.
// PORTS
//  rclk          in   1            read-domain clock
//  rrst_n        in   1            asynchronous active-low reset
//  r_en          in   1            read request from consumer
//  g_wptr        in   PTR_WIDTH+1  gray write pointer, driven from wclk domain (asynchronous)
//  ae_thresh     in   PTR_WIDTH+1  almost-empty threshold, quasi-static
//  rpop          out  1            combinational: r_en & ~empty; a word is consumed this cycle
//  raddr         out  PTR_WIDTH    RAM read address = b_rptr[PTR_WIDTH-1:0]
//  b_rptr        out  PTR_WIDTH+1  binary read pointer
//  g_rptr        out  PTR_WIDTH+1  gray read pointer, sent to wclk domain
//  empty         out  1            FIFO empty, registered
//  almost_empty  out  1            rlevel <= ae_thresh, registered
//  rlevel        out  PTR_WIDTH+1  words available, 0..2**PTR_WIDTH, registered
//  uf_clr        in   1            [RPTR_UNDERFLOW_EN only] clears the underflow flag
//  underflow     out  1            [RPTR_UNDERFLOW_EN only] sticky underflow flag
// BEHAVIOUR
//  Reset (asynchronous, rrst_n=0):
//  - All sync flops, b_rptr, g_rptr and rlevel = 0.
//  - empty = 1, almost_empty = 1, underflow = 0.
//  Synchroniser:
//  - g_wptr feeds sync[0]; each stage shifts every rclk.
//  - g_wptr_s = sync[SYNC_STAGES-1]. No logic between the stages.
//  Per-edge next-state values (combinational):
//  - rpop = r_en & ~empty. r_en while empty is ignored; pointers hold.
//  - b_next = b_rptr + rpop, modulo 2**(PTR_WIDTH+1); wraps 1111 -> 0000 for PTR_WIDTH=3.
//  - g_next = b_next ^ (b_next >> 1).
//  - w_bin = gray-to-binary of g_wptr_s, by XOR prefix from the MSB.
//  - lvl_next = w_bin - b_next, modulo 2**(PTR_WIDTH+1).
//  Registered at each rclk edge:
//  - b_rptr <= b_next; g_rptr <= g_next; rlevel <= lvl_next.
//  - empty <= (g_next == g_wptr_s).
//  - almost_empty <= (lvl_next <= ae_thresh), compared unsigned.
//  Latency:
//  - A pop updates raddr, b_rptr, g_rptr, rlevel and empty on the next edge. Back-to-back pops run at one per cycle.
//  - A g_wptr change becomes visible in empty/rlevel on the (SYNC_STAGES+1)th rising rclk edge after it is stable at the input.
//  Boundaries:
//  - Last word: a pop at rlevel=1 with no newly synchronised write makes empty=1 and rlevel=0 on the same edge.
//  - Pop and new write in the same cycle: rlevel = w_bin - b_next. Net change is 0 when one word is written and one popped.
//  - Full FIFO: rlevel = 2**PTR_WIDTH (MSBs differ, low bits equal); empty = 0.
//  - ae_thresh >= 2**PTR_WIDTH forces almost_empty = 1. While empty = 1, almost_empty = 1 for any ae_thresh.
//  - Reset mid-operation: outputs go to their reset values immediately; pending pops are lost.
//  - Pessimism: rlevel may under-report by up to SYNC_STAGES+1 cycles of writes. It never over-reports.
// CONFIGURATION
//  RPTR_UNDERFLOW_EN defined:
//  - Ports uf_clr and underflow exist.
//  - underflow <= 1 on any edge with r_en & empty.
//  - uf_clr=1 clears the flag to 0 on the next edge. If uf_clr and a new underflow coincide, set wins.
//  RPTR_UNDERFLOW_EN undefined:
//  - Neither port exists; no extra flops.
//  - Reads while empty are silently ignored.
// TESTING  (PTR_WIDTH=3, SYNC_STAGES=2)
//  1. Reset: release rrst_n with g_wptr=0 -> empty=1, almost_empty=1, rlevel=0, raddr=0, g_rptr=0000.
//  2. Sync latency: g_wptr 0000->0001 -> empty 1->0 and rlevel=1 on the 3rd rclk edge, not earlier.
//  3. Drain: g_wptr=gray(5)=0111, ae_thresh=2, r_en held 6 cycles.
//     - Expect 5 rpop pulses; raddr 0..4 then 5 held; rlevel 5,4,3,2,1,0.
//     - almost_empty rises when rlevel=2; empty=1 after the 5th pop.
//  4. Wrap and full: g_wptr=gray(8)=1100 with b_rptr=0 -> rlevel=8, empty=0.
//     - 8 pops -> b_rptr=1000, raddr=0, g_rptr=1100, empty=1.
//     - Continue 16 words total -> b_rptr=0000.
//  5. Underflow (RPTR_UNDERFLOW_EN): r_en=1 while empty -> pointers unchanged, underflow=1 next edge.
//     - uf_clr=1 -> underflow=0. Without the macro, same stimulus -> pointers unchanged, no underflow port.
//  6. Async reset mid-drain: assert rrst_n between edges at rlevel=3 -> outputs reset at once without a clock edge.

Source files
------------

// File: rtl/rptr_ctrl_sync.sv
// rptr_ctrl_sync: read-side pointer controller for the async FIFO.
// Brings the wclk-domain gray write pointer across with a SYNC_STAGES-deep
// flop chain, keeps the binary/gray read pointers and the RAM read address,
// and registers empty, almost_empty and the fill level in the rclk domain.
// Optional feature: define RPTR_UNDERFLOW_EN to add the uf_clr input and the
// sticky underflow output.
module rptr_ctrl_sync #(
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 r_en,
  input  logic [PTR_WIDTH:0]   g_wptr,
  input  logic [PTR_WIDTH:0]   ae_thresh,
`ifdef RPTR_UNDERFLOW_EN
  input  logic                 uf_clr,
  output logic                 underflow,
`endif
  output logic                 rpop,
  output logic [PTR_WIDTH-1:0] raddr,
  output logic [PTR_WIDTH:0]   b_rptr,
  output logic [PTR_WIDTH:0]   g_rptr,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   rlevel
);

  localparam int PW = PTR_WIDTH + 1;

  // sync[0] is the metastability-catching flop; sync[SYNC_STAGES-1] is safe to use
  logic [SYNC_STAGES-1:0][PW-1:0] sync;
  logic [PW-1:0] g_wptr_s;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] b_next;
  logic [PW-1:0] g_next;
  logic [PW-1:0] lvl_next;

  // plain shift chain, nothing between stages so each flop has a full cycle to settle
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= g_wptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  end

  assign g_wptr_s = sync[SYNC_STAGES-1];

  // gray -> binary: bit i is the XOR of all gray bits from the MSB down to i
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < PW; i++) w_bin[i] = ^(g_wptr_s >> i);
  end

  // a read while empty is dropped here, so pointers can never pass the write side
  assign rpop     = r_en & ~empty;
  assign b_next   = b_rptr + PW'(rpop);
  assign g_next   = b_next ^ (b_next >> 1);
  assign lvl_next = w_bin - b_next;
  assign raddr    = b_rptr[PTR_WIDTH-1:0];

  // pointer and status registers; status is computed from the post-pop pointer
  // so the last pop and the empty flag land on the same edge
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      rlevel       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      b_rptr       <= b_next;
      g_rptr       <= g_next;
      rlevel       <= lvl_next;
      empty        <= (g_next == g_wptr_s);
      almost_empty <= (lvl_next <= ae_thresh);
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  // sticky underflow: a new underflow beats a simultaneous clear
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)             underflow <= 1'b0;
    else if (r_en && empty)  underflow <= 1'b1;
    else if (uf_clr)         underflow <= 1'b0;
  end
`endif

endmodule
